// File: rtl/r_serial_ctrl_pkg.sv
// Shared types and constants for the serial-R requester controller.
// Holds the fixed-point defaults, operand word indices and FSM state encoding.
package r_serial_ctrl_pkg;

    localparam int FXP_N         = 16;
    localparam int FXP_FRAC      = 8;
    localparam int R_TIMEOUT_DEF = 8;

    // Operand word slots held by the buffer and the rs_* operand register bank.
    localparam int NWORDS = 9;
    localparam int W_Z00  = 0;
    localparam int W_Z10  = 1;
    localparam int W_ZH00 = 2;
    localparam int W_ZH10 = 3;
    localparam int W_BETA = 4;
    localparam int W_S00  = 5;
    localparam int W_S01  = 6;
    localparam int W_S10  = 7;
    localparam int W_S11  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_e;

    // Largest positive value of an n-bit two's-complement word.
    function automatic logic [63:0] fxp_max(input int unsigned n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/r_serial_ctrl_if.sv
// Bundle of all handshake and data signals around r_serial_ctrl.
// master = the controller itself; slave = its environment (innovation stage, R block, gain stage).
interface r_serial_ctrl_if
    import r_serial_ctrl_pkg::*;
#(
    parameter int N = FXP_N
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] z00, z10, zhat00, zhat10;
    logic signed [N-1:0] beta, sigma2_00, sigma2_01, sigma2_10, sigma2_11;

    logic                rs_start;
    logic signed [N-1:0] rs_beta, rs_sigma2_00, rs_sigma2_01, rs_sigma2_10, rs_sigma2_11;
    logic signed [N-1:0] rs_z00, rs_z10, rs_zhat00, rs_zhat10;
    logic                rs_done;
    logic signed [N-1:0] rs_R11, rs_R22;

    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] R11, R12, R21, R22;
    logic                err_timeout;

    modport master (
        input  in_valid, z00, z10, zhat00, zhat10,
               beta, sigma2_00, sigma2_01, sigma2_10, sigma2_11,
               rs_done, rs_R11, rs_R22, out_ready,
        output in_ready, rs_start,
               rs_beta, rs_sigma2_00, rs_sigma2_01, rs_sigma2_10, rs_sigma2_11,
               rs_z00, rs_z10, rs_zhat00, rs_zhat10,
               out_valid, R11, R12, R21, R22, err_timeout
    );

    modport slave (
        output in_valid, z00, z10, zhat00, zhat10,
               beta, sigma2_00, sigma2_01, sigma2_10, sigma2_11,
               rs_done, rs_R11, rs_R22, out_ready,
        input  in_ready, rs_start,
               rs_beta, rs_sigma2_00, rs_sigma2_01, rs_sigma2_10, rs_sigma2_11,
               rs_z00, rs_z10, rs_zhat00, rs_zhat10,
               out_valid, R11, R12, R21, R22, err_timeout
    );

endinterface

// File: rtl/r_serial_ctrl_meas_skid_buf.sv
// One-entry holding buffer for a measurement pair plus its config words.
// Written on an accepted handshake while the controller is busy, drained from IDLE.
module meas_skid_buf
    import r_serial_ctrl_pkg::*;
#(
    parameter int N = FXP_N
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_i,
    input  logic [NWORDS-1:0][N-1:0]     data_i,
    input  logic                         rd_i,
    output logic                         full_o,
    output logic [NWORDS-1:0][N-1:0]     data_o
);

    logic                     full_q;
    logic [NWORDS-1:0][N-1:0] data_q;

    // Write and drain never coincide: writes happen only outside IDLE, drains only in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (rd_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/r_serial_ctrl.sv
// Requester-side controller for the serial R block: launches one R computation per
// measurement, waits for done with a timeout, and holds the diagonal R for the gain stage.
module r_serial_ctrl
    import r_serial_ctrl_pkg::*;
#(
    parameter int N       = FXP_N,
    parameter int FRAC    = FXP_FRAC,
    parameter int TIMEOUT = R_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    r_serial_ctrl_if.master bus
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0]  R_MAX = N'(fxp_max(N));

    if (TIMEOUT < 4 || FRAC < 0 || FRAC >= N) begin : g_bad_param
        $error("r_serial_ctrl: TIMEOUT must be >= 4 and FRAC within [0, N)");
    end

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NWORDS-1:0][N-1:0] ops_q, ops_d;
    logic [NWORDS-1:0][N-1:0] in_words, buf_words;
    logic [N-1:0]             r11_q, r11_d, r22_q, r22_d;
    logic                     err_q, err_d;
    logic                     buf_full, buf_wr, buf_rd, in_hs;

    always_comb begin
        in_words         = '0;
        in_words[W_Z00]  = bus.z00;
        in_words[W_Z10]  = bus.z10;
        in_words[W_ZH00] = bus.zhat00;
        in_words[W_ZH10] = bus.zhat10;
        in_words[W_BETA] = bus.beta;
        in_words[W_S00]  = bus.sigma2_00;
        in_words[W_S01]  = bus.sigma2_01;
        in_words[W_S10]  = bus.sigma2_10;
        in_words[W_S11]  = bus.sigma2_11;
    end

    assign in_hs  = bus.in_valid && !buf_full;
    // In IDLE an accepted sample goes straight into the operand bank, so only busy states buffer.
    assign buf_wr = in_hs && (state_q != ST_IDLE);

    meas_skid_buf #(.N(N)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_i   (buf_wr),
        .data_i (in_words),
        .rd_i   (buf_rd),
        .full_o (buf_full),
        .data_o (buf_words)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ops_d   = ops_q;
        r11_d   = r11_q;
        r22_d   = r22_q;
        err_d   = err_q;
        buf_rd  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (buf_full) begin
                    ops_d   = buf_words;
                    buf_rd  = 1'b1;
                    state_d = ST_LAUNCH;
                end else if (in_hs) begin
                    ops_d   = in_words;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes priority over a timeout landing on the same cycle
                if (bus.rs_done) begin
                    r11_d   = bus.rs_R11;
                    r22_d   = bus.rs_R22;
                    state_d = ST_HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    r11_d   = R_MAX;
                    r22_d   = R_MAX;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ops_q   <= '0;
            r11_q   <= '0;
            r22_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ops_q   <= ops_d;
            r11_q   <= r11_d;
            r22_q   <= r22_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready     = !buf_full;
    assign bus.rs_start     = (state_q == ST_LAUNCH);
    assign bus.rs_z00       = ops_q[W_Z00];
    assign bus.rs_z10       = ops_q[W_Z10];
    assign bus.rs_zhat00    = ops_q[W_ZH00];
    assign bus.rs_zhat10    = ops_q[W_ZH10];
    assign bus.rs_beta      = ops_q[W_BETA];
    assign bus.rs_sigma2_00 = ops_q[W_S00];
    assign bus.rs_sigma2_01 = ops_q[W_S01];
    assign bus.rs_sigma2_10 = ops_q[W_S10];
    assign bus.rs_sigma2_11 = ops_q[W_S11];

    assign bus.out_valid    = (state_q == ST_HOLD);
    assign bus.R11          = r11_q;
    assign bus.R12          = '0;
    assign bus.R21          = '0;
    assign bus.R22          = r22_q;
    assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_r_serial_ctrl.sv
// Bench for r_serial_ctrl: vector table plus scoreboard, with a stub R block whose
// done delay is set per transaction.
module tb_r_serial_ctrl;
    import r_serial_ctrl_pkg::*;

    localparam int N = 16;

    typedef logic [NWORDS-1:0][N-1:0] ops_t;
    typedef struct {
        logic [15:0] z00, z10, zh00, zh10, beta, s00, s01, s10, s11;
        int          dly;
        bit          never;
        logic [15:0] r11, r22;
        bit          to;
    } vec_t;
    typedef struct { logic [15:0] r11, r22; bit err; } exp_t;
    typedef struct { ops_t ops; int dly; bit never; } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    r_serial_ctrl_if #(.N(N)) bus ();
    r_serial_ctrl #(.N(N), .FRAC(8), .TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    vec_t vecs[6];
    exp_t exp_q[$];
    job_t job_q[$];
    int   checks = 0, failures = 0;
    int   n_starts = 0;
    bit   sticky = 1'b0;
    logic spur = 1'b0;
    logic stub_act = 1'b0;
    int   stub_cnt = 0;
    ops_t cur_ops, rs_ops;
    job_t sj;
    exp_t se;

    function automatic logic [31:0] u(input logic [15:0] x);
        return {16'd0, x};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    function automatic ops_t vops(input int i);
        ops_t o;
        o         = '0;
        o[W_Z00]  = vecs[i].z00;  o[W_Z10]  = vecs[i].z10;
        o[W_ZH00] = vecs[i].zh00; o[W_ZH10] = vecs[i].zh10;
        o[W_BETA] = vecs[i].beta; o[W_S00]  = vecs[i].s00;
        o[W_S01]  = vecs[i].s01;  o[W_S10]  = vecs[i].s10;
        o[W_S11]  = vecs[i].s11;
        return o;
    endfunction

    always_comb begin
        rs_ops         = '0;
        rs_ops[W_Z00]  = bus.rs_z00;    rs_ops[W_Z10]  = bus.rs_z10;
        rs_ops[W_ZH00] = bus.rs_zhat00; rs_ops[W_ZH10] = bus.rs_zhat10;
        rs_ops[W_BETA] = bus.rs_beta;   rs_ops[W_S00]  = bus.rs_sigma2_00;
        rs_ops[W_S01]  = bus.rs_sigma2_01; rs_ops[W_S10] = bus.rs_sigma2_10;
        rs_ops[W_S11]  = bus.rs_sigma2_11;
    end

    // Stub R block: result is a fixed function of the held operands.
    assign bus.rs_done = spur | (stub_act && stub_cnt == 0);
    assign bus.rs_R11  = bus.rs_z00 - bus.rs_zhat00 + bus.rs_sigma2_00 + bus.rs_sigma2_01;
    assign bus.rs_R22  = bus.rs_z10 - bus.rs_zhat10 + bus.rs_sigma2_10 + bus.rs_sigma2_11 + bus.rs_beta;

    always @(negedge clk) begin
        if (!rst_n) begin
            stub_act <= 1'b0;
        end else if (bus.rs_start) begin
            n_starts <= n_starts + 1;
            if (job_q.size() == 0) fail_now("stub_unexpected_start");
            else begin
                sj = job_q.pop_front();
                for (int w = 0; w < NWORDS; w++)
                    chk($sformatf("ops_start[%0d]", w), u(rs_ops[w]), u(sj.ops[w]));
                cur_ops  <= sj.ops;
                stub_act <= !sj.never;
                stub_cnt <= sj.dly;
            end
        end else if (stub_act) begin
            if (stub_cnt == 0) begin
                stub_act <= 1'b0;
                for (int w = 0; w < NWORDS; w++)
                    chk($sformatf("ops_hold[%0d]", w), u(rs_ops[w]), u(cur_ops[w]));
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Scoreboard: compare each delivered R against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) fail_now("sb_unexpected_delivery");
            else begin
                se = exp_q.pop_front();
                chk("sb_R11", u(bus.R11), u(se.r11));
                chk("sb_R22", u(bus.R22), u(se.r22));
                chk("sb_R12", u(bus.R12), 32'd0);
                chk("sb_R21", u(bus.R21), 32'd0);
                chk("sb_err", {31'd0, bus.err_timeout}, {31'd0, se.err});
            end
        end
    end

    task automatic drive(input int i);
        bus.z00 = vecs[i].z00;  bus.z10 = vecs[i].z10;
        bus.zhat00 = vecs[i].zh00; bus.zhat10 = vecs[i].zh10;
        bus.beta = vecs[i].beta;
        bus.sigma2_00 = vecs[i].s00; bus.sigma2_01 = vecs[i].s01;
        bus.sigma2_10 = vecs[i].s10; bus.sigma2_11 = vecs[i].s11;
        bus.in_valid = 1'b1;
    endtask

    // Offers vector i; returns just after the accepting edge with in_valid dropped.
    task automatic send(input int i, output int waits);
        if (clk == 1'b0) begin @(posedge clk); #1; end
        drive(i);
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 60) begin waits++; @(negedge clk); end
        if (!bus.in_ready) begin
            fail_now($sformatf("send_timeout vec%0d", i));
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sticky = sticky | vecs[i].to;
        exp_q.push_back('{vecs[i].r11, vecs[i].r22, sticky});
        job_q.push_back('{vops(i), vecs[i].dly, vecs[i].never});
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 80) begin @(negedge clk); c++; end
        chk({nm, "_drain_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c, stale, starts0;
        //          z00      z10      zh00     zh10     beta     s00      s01      s10      s11     dly nev  r11      r22     to
        vecs[0] = '{16'h0100,16'h0050,16'h0080,16'h0010,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000, 3, 0, 16'h0080,16'h0040, 0};
        vecs[1] = '{16'h1000,16'h2000,16'h0800,16'h0400,16'h0010,16'h0001,16'h0002,16'h0003,16'h0004, 3, 0, 16'h0803,16'h1C17, 0};
        vecs[2] = '{16'h0000,16'h0000,16'h0001,16'h0001,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000, 5, 0, 16'hFFFF,16'hFFFF, 0};
        vecs[3] = '{16'h7000,16'h0100,16'h1000,16'h0200,16'h0005,16'h0010,16'h0020,16'h0030,16'h0040, 1, 0, 16'h6030,16'hFF75, 0};
        vecs[4] = '{16'h0200,16'h0300,16'h0100,16'h0100,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000, 8, 0, 16'h0100,16'h0200, 0};
        vecs[5] = '{16'h0011,16'h0022,16'h0033,16'h0044,16'h0055,16'h0066,16'h0077,16'h0088,16'h0099, 0, 1, 16'h7FFF,16'h7FFF, 1};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.z00 = '0; bus.z10 = '0; bus.zhat00 = '0; bus.zhat10 = '0; bus.beta = '0;
        bus.sigma2_00 = '0; bus.sigma2_01 = '0; bus.sigma2_10 = '0; bus.sigma2_11 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_rs_start", {31'd0, bus.rs_start}, 32'd0);
        chk("rst_err", {31'd0, bus.err_timeout}, 32'd0);
        chk("rst_R11", u(bus.R11), 32'd0);
        chk("rst_rs_z00", u(bus.rs_z00), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single request: start in the acceptance cycle, out_valid four edges later.
        send(0, w);
        @(negedge clk); chk("lat_start", {31'd0, bus.rs_start}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("lat_not_valid_%0d", k), {31'd0, bus.out_valid}, 32'd0);
        end
        @(negedge clk); chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_drain("single");

        for (int i = 1; i <= 4; i++) begin
            send(i, w);
            wait_drain($sformatf("vec%0d", i));
        end

        // Back-to-back: second goes to the buffer, third stalls.
        send(1, w);
        send(2, w);
        chk("b2b_second_no_wait", w, 32'd0);
        drive(3);
        @(negedge clk); chk("b2b_stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        send(3, w);
        chk("b2b_third_stalled", {31'd0, (w > 0)}, 32'd1);
        wait_drain("b2b");

        // Backpressure, with a spurious done thrown in while holding.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        starts0 = n_starts;
        send(3, w);
        c = 0;
        while (!bus.out_valid && c < 30) begin @(negedge clk); c++; end
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            spur = (k == 2 || k == 3);
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_R11", u(bus.R11), u(vecs[3].r11));
            chk("bp_hold_R22", u(bus.R22), u(vecs[3].r22));
        end
        spur = 1'b0;
        chk("bp_no_restart", n_starts - starts0, 32'd1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_drain("bp");

        // Spurious done in IDLE.
        @(posedge clk); #1 spur = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("spur_idle_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("spur_idle_start", {31'd0, bus.rs_start}, 32'd0);
        end
        spur = 1'b0;
        send(0, w);
        wait_drain("after_spur");

        // Timeout: no done ever.
        send(5, w);
        c = 0;
        do begin @(negedge clk); c++; end while (!bus.out_valid && c < 40);
        chk("to_latency", c, 32'd10);
        wait_drain("timeout");
        repeat (3) @(negedge clk);
        chk("to_err_sticky", {31'd0, bus.err_timeout}, 32'd1);
        send(0, w);
        wait_drain("post_timeout");

        // Reset while waiting with the buffer full.
        send(5, w);
        send(1, w);
        repeat (3) @(negedge clk);
        chk("rstw_buf_full", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b0;
        exp_q.delete(); job_q.delete(); sticky = 1'b0;
        @(negedge clk);
        chk("rstw_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rstw_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstw_err", {31'd0, bus.err_timeout}, 32'd0);
        chk("rstw_R11", u(bus.R11), 32'd0);
        chk("rstw_R22", u(bus.R22), 32'd0);
        chk("rstw_rs_z00", u(bus.rs_z00), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid || bus.rs_start) stale++;
        end
        chk("rstw_no_stale", stale, 32'd0);
        send(0, w);
        wait_drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
